// File: rtl/regfile_seq_if.sv
// regfile_seq_if: instruction handshake, ALU handshake and register-file command bundle.
// The sequencer connects through the slave modport; the instruction/ALU source uses master.
interface regfile_seq_if;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] op;
    logic [2:0] rn;
    logic [7:0] imm;
    logic       alu_done;
    logic       alu_start;
    logic [2:0] mux_sel;
    logic [2:0] reg_sel;
    logic [1:0] enab;
    logic [2:0] seg;
    logic [7:0] or2;
    logic       done;
    logic       err;

    modport master (
        output instr_valid, op, rn, imm, alu_done,
        input  instr_ready, alu_start, mux_sel, reg_sel, enab, seg, or2, done, err
    );

    modport slave (
        input  instr_valid, op, rn, imm, alu_done,
        output instr_ready, alu_start, mux_sel, reg_sel, enab, seg, or2, done, err
    );
endinterface

// File: rtl/regfile_seq.sv
// regfile_seq: sequences register-file commands and an external ALU for one instruction at a time.
// Define REGFILE_SEQ_TIMEOUT_EN to bound the ALU wait to ALU_TMO cycles (error completion).
module regfile_seq #(
    parameter int unsigned ALU_TMO = 15
) (
    input logic          clk,
    input logic          rst_n,
    regfile_seq_if.slave bus
);
    typedef enum logic [2:0] {
        StIdle, StClear, StWrite, StRead, StWaitAlu, StWb, StDone
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] op_q, op_d, rn_q, rn_d;
    logic [7:0] or2_q, or2_d;
    logic [2:0] mux_q, mux_d, rsel_q, rsel_d, seg_q, seg_d;
    logic [1:0] enab_q, enab_d;
    logic       ready_q, ready_d, start_q, start_d, done_q, done_d, err_q, err_d;
    logic       accept, tmo_hit;

    // ready_q is the registered copy of "in IDLE", so it also masks the first edge out of reset.
    assign accept = ready_q && bus.instr_valid;

`ifdef REGFILE_SEQ_TIMEOUT_EN
    localparam int unsigned CntW = (ALU_TMO > 1) ? $clog2(ALU_TMO) : 1;
    logic [CntW-1:0] cnt_q, cnt_d;

    // cnt_q holds the number of WAIT_ALU cycles already completed.
    assign cnt_d   = (state_q == StWaitAlu) ? cnt_q + CntW'(1) : '0;
    assign tmo_hit = (cnt_q == CntW'(ALU_TMO - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    logic unused_tmo;
    assign unused_tmo = |ALU_TMO;
    assign tmo_hit    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rn_d    = rn_q;
        or2_d   = or2_q;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d = bus.op;
                    rn_d = bus.rn;
                    unique case (bus.op)
                        3'b000:         state_d = StDone;
                        3'b001:         state_d = StClear;
                        3'b010, 3'b011: state_d = StWrite;
                        3'b100: begin
                            state_d = StWrite;
                            or2_d   = bus.imm;
                        end
                        3'b101:         state_d = StRead;
                        default: begin
                            state_d = StDone;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            StClear, StWrite, StWb: state_d = StDone;
            StRead:                 state_d = StWaitAlu;
            StWaitAlu: begin
                if (bus.alu_done) begin
                    state_d = StWb;
                end else if (tmo_hit) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end
            end
            StDone:                 state_d = StIdle;
            default:                state_d = StIdle;
        endcase

        // Outputs are decoded from the next state so they are registered with it.
        ready_d = (state_d == StIdle);
        enab_d  = 2'b10;
        mux_d   = 3'b000;
        rsel_d  = 3'b000;
        seg_d   = 3'b000;
        start_d = 1'b0;
        done_d  = 1'b0;
        case (state_d)
            StClear: enab_d = 2'b00;
            StWrite: begin
                enab_d = 2'b01;
                case (op_d)
                    3'b010: seg_d = rn_d;
                    3'b011: begin
                        mux_d  = 3'b001;
                        rsel_d = rn_d;
                    end
                    default: begin
                        mux_d = 3'b010;
                        seg_d = rn_d;
                    end
                endcase
            end
            StRead: begin
                enab_d  = 2'b11;
                seg_d   = rn_d;
                start_d = 1'b1;
            end
            StWb: begin
                enab_d = 2'b01;
                mux_d  = 3'b011;
            end
            StDone:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= 3'b000;
            rn_q    <= 3'b000;
            or2_q   <= 8'h00;
            ready_q <= 1'b0;
            enab_q  <= 2'b10;
            mux_q   <= 3'b000;
            rsel_q  <= 3'b000;
            seg_q   <= 3'b000;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rn_q    <= rn_d;
            or2_q   <= or2_d;
            ready_q <= ready_d;
            enab_q  <= enab_d;
            mux_q   <= mux_d;
            rsel_q  <= rsel_d;
            seg_q   <= seg_d;
            start_q <= start_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.instr_ready = ready_q;
    assign bus.enab        = enab_q;
    assign bus.mux_sel     = mux_q;
    assign bus.reg_sel     = rsel_q;
    assign bus.seg         = seg_q;
    assign bus.or2         = or2_q;
    assign bus.alu_start   = start_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
endmodule

// File: doc/regfile_seq.md
REGFILE_SEQ -- requirements
Module: regfile_seq

Interface
REQ-001 SHALL have parameter ALU_TMO, default 15, the maximum number of cycles spent waiting for alu_done.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port instr_valid, input, 1 bit: instruction offered.
REQ-005 SHALL have port instr_ready, output, 1 bit: sequencer accepts an instruction.
REQ-006 SHALL have port op, input, 3 bits: operation code.
REQ-007 SHALL have port rn, input, 3 bits: register index.
REQ-008 SHALL have port imm, input, 8 bits: immediate operand.
REQ-009 SHALL have port alu_done, input, 1 bit: ALU result valid.
REQ-010 SHALL have port alu_start, output, 1 bit: one-cycle ALU start pulse.
REQ-011 SHALL have port mux_sel, output, 3 bits: register-file write source select.
REQ-012 SHALL have port reg_sel, output, 3 bits: register-file source index.
REQ-013 SHALL have port enab, output, 2 bits: register-file command (00 clear, 01 write, 10 hold, 11 read).
REQ-014 SHALL have port seg, output, 3 bits: register-file target/read index.
REQ-015 SHALL have port or2, output, 8 bits: operand register 2 value.
REQ-016 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-017 SHALL have port err, output, 1 bit: completion was an error; valid only while done is high.

Function
REQ-018 SHALL register all outputs and implement FSM states IDLE, CLEAR, WRITE, READ, WAIT_ALU, WB and DONE.
REQ-019 SHALL drive instr_ready=1 only in IDLE; a transfer occurs when instr_valid and instr_ready are both high at a rising edge.
REQ-020 SHALL drive enab=10 in every state except CLEAR, WRITE, READ and WB; enab=00 or 01 SHALL last exactly one cycle.
REQ-021 SHALL handle op 000 (NOP) as accept -> DONE, with done high in the cycle after accept.
REQ-022 SHALL handle op 001 (CLR) as accept -> CLEAR for one cycle (enab=00) -> DONE.
REQ-023 SHALL handle op 010 (Rn<-R0) as WRITE for one cycle: mux_sel=000, seg=rn, enab=01.
REQ-024 SHALL handle op 011 (R0<-Rn) as WRITE for one cycle: mux_sel=001, reg_sel=rn, seg=000, enab=01.
REQ-025 SHALL handle op 100 (Rn<-imm) by latching or2=imm at accept, then WRITE for one cycle: mux_sel=010, seg=rn, enab=01.
REQ-026 SHALL handle op 101 (ALU) as READ for one cycle (enab=11, seg=rn, alu_start=1) -> WAIT_ALU until alu_done -> WB for one cycle (mux_sel=011, seg=000, enab=01) -> DONE.
REQ-027 SHALL treat op 110 and 111 as illegal: accept -> DONE with err=1 and no register-file command issued.
REQ-028 SHALL, in WAIT_ALU, honour alu_done in the first WAIT_ALU cycle (minimum ALU latency 1); alu_done outside WAIT_ALU SHALL be ignored.
REQ-029 SHALL latch rn and op at accept and hold them stable until DONE, independent of input changes.
REQ-030 SHALL hold DONE for exactly one cycle, then return to IDLE; back-to-back instructions therefore have a minimum spacing of 2 cycles (NOP) or 3 cycles (write).

Reset
REQ-031 SHALL, when rst_n=0, immediately force: state IDLE, instr_ready=0, enab=10, mux_sel=000, reg_sel=000, seg=000, or2=00, alu_start=0, done=0, err=0.
REQ-032 SHALL drive instr_ready=1 in the first cycle after rst_n deasserts.
REQ-033 SHALL, on reset asserted mid-operation, abandon the operation with no done pulse and no write.

Configuration
REQ-034 SHALL, with macro REGFILE_SEQ_TIMEOUT_EN defined, count WAIT_ALU cycles and, after ALU_TMO cycles without alu_done, go to DONE with err=1 and skip WB.
REQ-035 SHALL, with REGFILE_SEQ_TIMEOUT_EN undefined, wait in WAIT_ALU indefinitely and ignore ALU_TMO.

Verification
REQ-036 SHALL cover: reset, then CLR accepted at cycle 0 -> enab=00 at cycle 1 only, done=1 err=0 at cycle 2.
REQ-037 SHALL cover: op=100, rn=5, imm=A5 -> or2=A5, one cycle of mux_sel=010 seg=5 enab=01, then done.
REQ-038 SHALL cover: op=101, rn=3, alu_done 4 cycles after alu_start -> enab=11 seg=3, then WB mux_sel=011 seg=0 enab=01, done err=0.
REQ-039 SHALL cover: op=111 -> done=1 err=1, enab stays 10 throughout.
REQ-040 SHALL cover: with timeout enabled and ALU_TMO=15, op=101 with no alu_done -> done err=1 after 15 WAIT_ALU cycles and no enab=01.
REQ-041 SHALL cover: rst_n low during WAIT_ALU -> outputs at reset values immediately, no done pulse, instr_ready=1 the cycle after release.
